// File: rtl/cpu_exec_ctrl_pkg.sv
// Shared types and constants for the CPU execution controller and its key debouncer.
package cpu_exec_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    STEP  = 2'd1,
    RUN_N = 2'd2,
    FREE  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_STEP  = 2'd1,
    S_RUN   = 2'd2,
    S_BREAK = 2'd3
  } state_e;

  // 10 ms of stable key level at 50 MHz.
  localparam int unsigned DEB_CYCLES_DFLT = 500000;

  function automatic int unsigned deb_w(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam int unsigned DEB_W = deb_w(DEB_CYCLES_DFLT);

endpackage

// File: rtl/cpu_exec_ctrl_btn_debounce.sv
// Board-key debouncer: 2-FF synchroniser, stability counter and a one-clk pulse on
// each accepted press (debounced 1->0). Release yields no pulse. Reusable for any active-low key.
module btn_debounce
  import cpu_exec_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CW = deb_w(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  // Key idles high (released), so the synchroniser and level reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_n_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample (a bounce back) restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign press_d = level_q & ~level_d;

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/cpu_exec_ctrl.sv
// Clock-enable sequencer for the single-cycle core: halt/step/run-N/free-run, PC breakpoints
// and retired-instruction count. Breakpoint comparators exist only when CPU_EXEC_CTRL_BP_EN is defined.
module cpu_exec_ctrl
  import cpu_exec_ctrl_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NUM_BP     = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DFLT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     step_btn_n_i,
  input  logic [1:0]               mode_i,
  input  logic [CNT_W-1:0]         run_count_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [NUM_BP*XLEN-1:0]   bp_addr_i,
  input  logic [NUM_BP-1:0]        bp_en_i,
  output logic                     cpu_ce_o,
  output logic                     running_o,
  output logic [NUM_BP-1:0]        bp_hit_o,
  output logic [31:0]              instret_o
);

  logic press_c;
  logic key_level_unused;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_step_key (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n_i (step_btn_n_i),
    .level_o (key_level_unused),
    .press_o (press_c)
  );

  logic [1:0] mode_meta_q, mode_sync_q, mode_prev_q;
  logic       mode_chg_c;
  mode_e      mode_cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_meta_q <= 2'b00;
      mode_sync_q <= 2'b00;
      mode_prev_q <= 2'b00;
    end else begin
      mode_meta_q <= mode_i;
      mode_sync_q <= mode_meta_q;
      mode_prev_q <= mode_sync_q;
    end
  end

  assign mode_chg_c = (mode_sync_q != mode_prev_q);
  assign mode_cur   = mode_e'(mode_sync_q);

  logic [NUM_BP-1:0] bp_match_c;

`ifdef CPU_EXEC_CTRL_BP_EN
  for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
    assign bp_match_c[gi] = bp_en_i[gi] && (pc_i == bp_addr_i[gi*XLEN +: XLEN]);
  end
`else
  logic unused_bp_inputs;
  assign unused_bp_inputs = ^{pc_i, bp_addr_i, bp_en_i};
  assign bp_match_c       = '0;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              counted_q, counted_d;
  logic              first_q, first_d;
  logic [NUM_BP-1:0] bp_hit_q, bp_hit_d;
  logic [31:0]       instret_q;
  logic              abort_c, bp_stop_c;
  logic              cpu_ce_c, running_c;

  // A run may start on a breakpointed PC; only later cycles can stop on a match.
  assign abort_c   = press_c | mode_chg_c;
  assign bp_stop_c = (|bp_match_c) & ~first_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_HALT;
      rem_q     <= '0;
      counted_q <= 1'b0;
      first_q   <= 1'b0;
      bp_hit_q  <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      counted_q <= counted_d;
      first_q   <= first_d;
      bp_hit_q  <= bp_hit_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    counted_d = counted_q;
    first_d   = 1'b0;
    bp_hit_d  = bp_hit_q;
    if (press_c) begin
      bp_hit_d = '0;
    end
    case (state_q)
      S_HALT: begin
        if (press_c) begin
          case (mode_cur)
            STEP: state_d = S_STEP;
            RUN_N: begin
              if (run_count_i != '0) begin
                state_d   = S_RUN;
                rem_d     = run_count_i;
                counted_d = 1'b1;
                first_d   = 1'b1;
              end
            end
            FREE: begin
              state_d   = S_RUN;
              counted_d = 1'b0;
              first_d   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_STEP: state_d = S_HALT;
      S_RUN: begin
        if (abort_c) begin
          state_d = S_HALT;
        end else if (bp_stop_c) begin
          state_d  = S_BREAK;
          bp_hit_d = bp_hit_q | bp_match_c;
        end else if (counted_q) begin
          if (rem_q == CNT_W'(1)) begin
            state_d = S_HALT;
          end
          rem_d = rem_q - CNT_W'(1);
        end
      end
      S_BREAK: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // ce is combinational so a matching PC suppresses it in the very cycle it appears.
  always_comb begin
    cpu_ce_c  = 1'b0;
    running_c = 1'b0;
    case (state_q)
      S_STEP: cpu_ce_c = 1'b1;
      S_RUN: begin
        running_c = 1'b1;
        cpu_ce_c  = ~abort_c & ~bp_stop_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (cpu_ce_c) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign cpu_ce_o  = cpu_ce_c;
  assign running_o = running_c;
  assign instret_o = instret_q;

`ifdef CPU_EXEC_CTRL_BP_EN
  assign bp_hit_o = bp_hit_q;
`else
  assign bp_hit_o = '0;
`endif

endmodule

// File: doc/cpu_exec_ctrl.md
# cpu_exec_ctrl

Execution controller for the single-cycle RISC-V core: replaces the bare inverted-button clock with a single clock domain plus one-cycle clock-enable pulses. It debounces the step key and supports halt, single-step, run-N and free-run modes. It stops on any of NUM_BP PC breakpoints and counts retired instructions for the VGA debug view. It sits between board inputs and the CPU's PC/register/data-memory enables.

## Interface
- XLEN, 32, PC width
- NUM_BP, 4, breakpoint comparator channels (1..8)
- CNT_W, 16, width of run_count and remaining-step counter
- DEB_CYCLES, 500000, stable-input cycles required to accept a key edge (10 ms at 50 MHz)
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- step_btn_n  in  1  raw board key, active-low, asynchronous to clk
- mode  in  2  0 HALT, 1 STEP, 2 RUN_N, 3 FREE; raw switches, synchronised internally
- run_count  in  CNT_W  instructions to execute in RUN_N; sampled on the accepted press
- pc  in  XLEN  current CPU PC
- bp_addr  in  NUM_BP*XLEN  breakpoint addresses, channel k at [k*XLEN +: XLEN]
- bp_en  in  NUM_BP  per-channel enable
- cpu_ce  out  1  one-clk enable; the CPU commits exactly one instruction per high cycle
- running  out  1  high in S_RUN
- bp_hit  out  NUM_BP  sticky mask of channels that stopped execution; cleared on next accepted press
- instret  out  32  retired-instruction count, wraps 0xFFFFFFFF->0

## Operation
- Key path: 2-FF synchroniser. The debounced level changes only after DEB_CYCLES consecutive equal samples. A debounced 1->0 transition yields `press`, a one-clk pulse. Release produces nothing.
- Mode path: 2-FF synchroniser. `mode_chg` fires when the synchronised value differs from the previous cycle.
- States: S_HALT, S_STEP, S_RUN, S_BREAK.
- S_HALT:
  - press && mode==STEP -> S_STEP.
  - press && mode==RUN_N && run_count!=0 -> load rem=run_count, S_RUN.
  - press && mode==RUN_N && run_count==0 -> stay in S_HALT.
  - press && mode==FREE -> S_RUN, with rem ignored.
  - press && mode==HALT -> ignored.
  - Every accepted press clears bp_hit.
- S_STEP: assert cpu_ce for one cycle, then -> S_HALT. Breakpoints are ignored, so stepping off a breakpoint is always possible.
- S_RUN: assert cpu_ce every cycle except when one of these terminates the run:
  - (a) Breakpoint match: some k with bp_en[k] && pc==bp_addr[k], and this is not the first S_RUN cycle. Set bp_hit[k] for all matching k, deassert cpu_ce, -> S_BREAK.
  - (b) RUN_N: ce issued with rem==1 -> S_HALT next cycle. Otherwise decrement rem on each ce.
  - (c) press or mode_chg -> S_HALT, with no ce that cycle.
  - Priority: (c) > (a) > (b).
- The first-cycle breakpoint exemption lets a run resume from a breakpointed PC.
- S_BREAK: one cycle, -> S_HALT. It exists so bp_hit and running settle together.
- instret increments on every cpu_ce cycle.

## Timing
- Reset values: cpu_ce=0, running=0, bp_hit=0, instret=0, state S_HALT, rem=0, debounced key=1 (released), synchronisers=1 for key and 0 for mode.
- Latency:
  - Key fall to press: 2 sync cycles plus DEB_CYCLES.
  - press to the first cpu_ce: 1 cycle.
  - RUN_N: exactly run_count consecutive ce cycles, no gaps.
- Breakpoint compare is combinational on pc, which the CPU updates at the same edge that consumes ce. ce is deasserted in the same cycle the matching PC appears, so the matching instruction is not executed.
- Reset asserted mid-run: all state clears asynchronously and cpu_ce drops immediately.
- Key bounce shorter than DEB_CYCLES produces no press.

## Configuration
- CPU_EXEC_CTRL_BP_EN:
  - Defined: NUM_BP comparators and bp_hit logic are built.
  - Undefined: no comparators, bp_hit tied 0, and termination condition (a) never fires. Ports remain present; bp_addr and bp_en are unused.

## Structure
- Package cpu_exec_ctrl_pkg holds:
  - mode_e: HALT/STEP/RUN_N/FREE.
  - state_e: S_HALT/S_STEP/S_RUN/S_BREAK.
  - Localparam DEB_W = $clog2(DEB_CYCLES+1).
- Sub-module btn_debounce (parameter DEB_CYCLES) contains the synchroniser, stability counter and press-pulse generator. It is reusable for other board keys.

## Test plan
- Reset, DEB_CYCLES=8, bounce step_btn_n 3 times within 5 cycles then hold low -> exactly one press, one cpu_ce in STEP mode, instret=1.
- RUN_N with run_count=5, press -> 5 consecutive cpu_ce cycles, running high 5 cycles, then S_HALT, instret=5.
- FREE, bp_en=4'b0100, bp_addr[2]=0x0000_0010, model pc+=4 per ce from 0 -> ce for pc 0,4,8,0xC; stop at 0x10; bp_hit=4'b0100. A second press resumes past 0x10 and clears bp_hit.
- FREE running, change mode to STEP -> cpu_ce drops within 3 cycles (sync plus 1), state S_HALT, no extra ce.
- RUN_N with run_count=0, press -> no cpu_ce, instret unchanged. Preload instret to 0xFFFF_FFFF via ce, one more ce -> 0.
- Assert rst_n low during a RUN_N of 100 -> cpu_ce=0 immediately, instret=0, bp_hit=0. After release, no ce until a new press.
